// File: rtl/display_pkg.sv
// Shared display constants so the feeder and the seven-segment decoder agree on
// word width, digit count and scan rate.
package display_pkg;

  localparam int DISP_W               = 16;
  localparam int SEG_DIGITS           = 4;
  localparam int SCAN_DIV_DEFAULT     = 100000;
  localparam int DEBOUNCE_CYC_DEFAULT = 1000000;

  function automatic logic [DISP_W-1:0] pick_half(input logic [2*DISP_W-1:0] word,
                                                  input logic                upper);
    if (upper) begin
      return word[2*DISP_W-1:DISP_W];
    end else begin
      return word[DISP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module btn_debounce
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_step
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic [1:0]       r_sync_vld;
  logic             r_stable;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step;
  logic             w_differ;
  logic             w_settled;

  assign w_differ  = r_sync1 ^ r_stable;
  assign w_settled = w_differ & (r_cnt == CNT_LAST);
  assign o_step    = r_step;

  // Armed only once a genuine post-reset released sample is seen, so a button
  // held through reset must be released before it can step again.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0    <= 1'b0;
      r_sync1    <= 1'b0;
      r_sync_vld <= 2'b00;
      r_stable   <= 1'b0;
      r_armed    <= 1'b0;
      r_cnt      <= CNT_W'(0);
      r_step     <= 1'b0;
    end else begin
      r_sync0    <= i_btn;
      r_sync1    <= r_sync0;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (!w_differ || w_settled) begin
        r_cnt <= CNT_W'(0);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_settled) begin
        r_stable <= r_sync1;
      end
      r_armed <= r_armed | (r_sync_vld[1] & ~r_sync1 & ~r_stable);
      r_step  <= w_settled & r_sync1 & r_armed;
    end
  end

endmodule

// File: rtl/result_display_feeder.sv
// Captures write-back results into a FIFO, pops one per debounced button press
// and drives the display word, scan tick and restart pulse for the decoder.
module result_display_feeder
  import display_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 8,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int SCAN_DIV     = SCAN_DIV_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWriteW,
  input  logic [DATA_W-1:0]        ResultW,
  input  logic                     btn_next,
  input  logic                     half_sel,
  output logic [DISP_W-1:0]        disp_value,
  output logic                     disp_valid,
  output logic                     scan_tick,
  output logic                     restart,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_disp;
  logic              r_disp_valid;
  logic              r_overflow;
  logic              r_half_q;
  logic              r_restart;
  logic              r_scan_tick;
  logic [PW-1:0]     r_presc;
  logic              w_step;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_next),
    .o_step (w_step)
  );

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));
  assign w_pop   = w_step & ~w_empty;
  // A full FIFO still accepts a write when the same cycle frees the head slot.
  assign w_push  = RegWriteW & (~w_full | w_pop);
  assign w_drop  = RegWriteW & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= ResultW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp       <= DATA_W'(0);
      r_disp_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_half_q     <= 1'b0;
      r_restart    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_disp       <= r_mem[r_rd_ptr];
        r_disp_valid <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_half_q  <= half_sel;
      r_restart <= w_pop | (half_sel ^ r_half_q);
    end
  end

  // Free-running scan prescaler; the tick is registered so it is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc     <= PW'(0);
      r_scan_tick <= 1'b0;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= PW'(0);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_scan_tick <= (r_presc == PRESC_LAST);
    end
  end

  assign disp_value = pick_half(r_disp[2*DISP_W-1:0], half_sel);
  assign disp_valid = r_disp_valid;
  assign scan_tick  = r_scan_tick;
  assign restart    = r_restart;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_result_display_feeder.sv
// Directed bench for result_display_feeder with short debounce/scan constants.
module tb_result_display_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [31:0] ResultW;
  logic        btn_next;
  logic        half_sel;
  logic [15:0] disp_value;
  logic        disp_valid;
  logic        scan_tick;
  logic        restart;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_chk = 0;
  int n_bad = 0;

  result_display_feeder #(
    .DATA_W(32), .DEPTH(4), .DEBOUNCE_CYC(4), .SCAN_DIV(5)
  ) dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultW(ResultW),
    .btn_next(btn_next), .half_sel(half_sel), .disp_value(disp_value),
    .disp_valid(disp_valid), .scan_tick(scan_tick), .restart(restart),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; RegWriteW = 1'b0; ResultW = 32'h0; btn_next = 1'b0; half_sel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    RegWriteW = 1'b1; ResultW = v;
    @(negedge clk);
    RegWriteW = 1'b0;
  endtask

  task automatic hold_btn(input logic lvl, input int ncyc, output int n_rst, output int first);
    btn_next = lvl; n_rst = 0; first = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (restart) begin
        n_rst++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic press(output int n_rst);
    int a, b, f;
    hold_btn(1'b1, 10, a, f);
    hold_btn(1'b0, 8, b, f);
    n_rst = a + b;
  endtask

  initial begin
    int n, f, nb;
    reset = 1'b1; RegWriteW = 1'b0; ResultW = 32'h0; btn_next = 1'b0; half_sel = 1'b0;

    // 1: basic push/pop and half select
    do_reset();
    check("rst_disp", {16'h0, disp_value}, 32'h0);
    check("rst_valid", {31'h0, disp_valid}, 32'h0);
    check("rst_count", {29'h0, fifo_count}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    check("rst_tick", {31'h0, scan_tick}, 32'h0);
    check("rst_restart", {31'h0, restart}, 32'h0);
    push(32'h12345678);
    push(32'hCAFEBABE);
    check("t1_count2", {29'h0, fifo_count}, 32'd2);
    press(n);
    check("t1_rst1", n, 32'd1);
    check("t1_lo", {16'h0, disp_value}, 32'h5678);
    check("t1_valid", {31'h0, disp_valid}, 32'h1);
    check("t1_count1", {29'h0, fifo_count}, 32'd1);
    half_sel = 1'b1;
    #1;
    check("t1_hi_comb", {16'h0, disp_value}, 32'h1234);
    @(negedge clk);
    check("t1_half_rst", {31'h0, restart}, 32'h1);
    @(negedge clk);
    check("t1_half_rst_end", {31'h0, restart}, 32'h0);
    press(n);
    check("t1_rst2", n, 32'd1);
    check("t1_hi2", {16'h0, disp_value}, 32'hCAFE);
    check("t1_count0", {29'h0, fifo_count}, 32'd0);
    half_sel = 1'b0;
    @(negedge clk);
    check("t1_half_rst2", {31'h0, restart}, 32'h1);
    check("t1_lo2", {16'h0, disp_value}, 32'hBABE);
    @(negedge clk);

    // 2: overflow and ordering
    do_reset();
    for (int i = 1; i <= 5; i++) push(32'h1111 * i);
    check("t2_count", {29'h0, fifo_count}, 32'd4);
    check("t2_ovf", {31'h0, overflow}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      press(n);
      check($sformatf("t2_rst%0d", i), n, 32'd1);
      check($sformatf("t2_pop%0d", i), {16'h0, disp_value}, 32'h1111 * i);
    end
    press(n);
    check("t2_empty_rst", n, 32'd0);
    check("t2_empty_disp", {16'h0, disp_value}, 32'h4444);
    check("t2_empty_cnt", {29'h0, fifo_count}, 32'd0);
    check("t2_ovf_sticky", {31'h0, overflow}, 32'h1);

    // 3: push and pop on the same cycle while full
    do_reset();
    for (int i = 1; i <= 4; i++) push(32'hB0 + i);
    check("t3_full", {29'h0, fifo_count}, 32'd4);
    btn_next = 1'b1;
    repeat (6) @(negedge clk);
    RegWriteW = 1'b1; ResultW = 32'hB5;
    @(negedge clk);
    RegWriteW = 1'b0;
    check("t3_count", {29'h0, fifo_count}, 32'd4);
    check("t3_ovf", {31'h0, overflow}, 32'h0);
    check("t3_pop1", {16'h0, disp_value}, 32'hB1);
    hold_btn(1'b1, 4, n, f);
    hold_btn(1'b0, 8, n, f);
    for (int i = 2; i <= 5; i++) begin
      press(n);
      check($sformatf("t3_pop%0d", i), {16'h0, disp_value}, 32'hB0 + i);
    end
    check("t3_ovf_end", {31'h0, overflow}, 32'h0);

    // 4: bouncing button
    do_reset();
    push(32'hC001);
    push(32'hC002);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 2) % 2 == 0);
      @(negedge clk);
      if (restart) nb++;
    end
    check("t4_bounce_quiet", nb, 32'd0);
    hold_btn(1'b1, 12, n, f);
    check("t4_one_pop", n, 32'd1);
    check("t4_latency", f, 32'd7);
    check("t4_disp", {16'h0, disp_value}, 32'hC001);
    check("t4_count", {29'h0, fifo_count}, 32'd1);
    hold_btn(1'b0, 8, n, f);

    // 5: scan tick cadence with a pop in the middle
    do_reset();
    nb = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check($sformatf("t5_tick%0d", k), {31'h0, scan_tick}, {31'h0, (k % 5 == 0)});
      if (restart) nb++;
      if (k == 2) begin RegWriteW = 1'b1; ResultW = 32'hA5A5; end
      if (k == 3) RegWriteW = 1'b0;
      if (k == 4) btn_next = 1'b1;
      if (k == 25) btn_next = 1'b0;
    end
    check("t5_popped", nb, 32'd1);
    hold_btn(1'b0, 8, n, f);

    // 6: reset with entries stored and button held
    do_reset();
    for (int i = 1; i <= 4; i++) push(32'hE0 + i);
    hold_btn(1'b1, 10, n, f);
    check("t6_prepop", {29'h0, fifo_count}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("t6_disp", {16'h0, disp_value}, 32'h0);
    check("t6_valid", {31'h0, disp_valid}, 32'h0);
    check("t6_count", {29'h0, fifo_count}, 32'h0);
    check("t6_ovf", {31'h0, overflow}, 32'h0);
    check("t6_tick", {31'h0, scan_tick}, 32'h0);
    check("t6_restart", {31'h0, restart}, 32'h0);
    reset = 1'b0;
    push(32'hE9);
    hold_btn(1'b1, 15, n, f);
    check("t6_held_nopop", n, 32'd0);
    check("t6_held_cnt", {29'h0, fifo_count}, 32'd1);
    hold_btn(1'b0, 8, n, f);
    press(n);
    check("t6_repress", n, 32'd1);
    check("t6_repress_disp", {16'h0, disp_value}, 32'hE9);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
